// File: rtl/crc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// crc_frame_ctrl
//
// Frame-level sequencer around a byte-wide CRC-8 engine. Payload bytes arrive
// on a valid/ready stream, are forwarded unchanged through a single-entry
// output register, and one CRC byte is appended after the last byte of every
// frame. The block owns CRC init, update and release for each frame.
//
// Optional feature macro: CRC_XOROUT_EN
//   defined   : the appended CRC byte is crc ^ XOROUT
//   undefined : the appended CRC byte is the raw crc register
//   The running CRC register itself is never XORed.
//
// Parameters:
//   POLY    CRC-8 generator polynomial, x^8 term implicit
//   INIT    CRC register value at reset and at the start of each frame
//   XOROUT  output XOR mask (only effective with CRC_XOROUT_EN)
//   CNT_W   width of the completed-frame counter
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   s_valid    upstream byte valid
//   s_ready    upstream byte accepted when s_valid && s_ready
//   s_data     upstream byte
//   s_last     byte is the final byte of its frame
//   m_valid    downstream beat valid
//   m_ready    downstream ready
//   m_data     payload byte or CRC byte
//   m_last     high only on the appended CRC beat
//   m_is_crc   high only on the appended CRC beat
//   in_frame   high from the first accepted byte until the CRC beat is loaded
//   frame_cnt  number of CRC beats loaded, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module crc_frame_ctrl #(
    parameter logic [7:0] POLY   = 8'hED,
    parameter logic [7:0] INIT   = 8'h00,
    parameter logic [7:0] XOROUT = 8'hFF,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             m_is_crc,
    output logic             in_frame,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [0:0] ST_PASS   = 1'b0;
    localparam logic [0:0] ST_APPEND = 1'b1;

`ifdef CRC_XOROUT_EN
    localparam logic XOR_EN = 1'b1;
`else
    localparam logic XOR_EN = 1'b0;
`endif

    // Mask applied to the appended byte only; collapses to zero when the
    // output XOR feature is compiled out.
    localparam logic [7:0] CRC_OUT_MASK = XOROUT & {8{XOR_EN}};

    logic [0:0] state;
    logic [7:0] crc;
    logic [7:0] crc_next;
    logic       out_free;
    logic       accept;

    // MSB-first CRC-8 over one full byte, unrolled over eight bit steps.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                             input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
        end
        return c;
    endfunction

    // The output register can take a new beat when it is empty or its current
    // beat is being consumed this cycle.
    assign out_free = !m_valid || m_ready;
    assign s_ready  = (state == ST_PASS) && out_free;
    assign accept   = s_valid && s_ready;

    // NOTE: every variable written in an always_comb gets a value on every
    // path (here a single unconditional assignment), so no latch is inferred.
    always_comb begin
        crc_next = crc8_byte(crc, s_data);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PASS;
            crc       <= INIT;
            m_valid   <= 1'b0;
            m_data    <= 8'h00;
            m_last    <= 1'b0;
            m_is_crc  <= 1'b0;
            in_frame  <= 1'b0;
            frame_cnt <= '0;
        end else if (out_free) begin
            if (state == ST_APPEND) begin
                // Release the finished CRC and re-arm for the next frame.
                m_data    <= crc ^ CRC_OUT_MASK;
                m_valid   <= 1'b1;
                m_last    <= 1'b1;
                m_is_crc  <= 1'b1;
                crc       <= INIT;
                in_frame  <= 1'b0;
                frame_cnt <= frame_cnt + CNT_W'(1);
                state     <= ST_PASS;
            end else if (accept) begin
                m_data   <= s_data;
                m_valid  <= 1'b1;
                m_last   <= 1'b0;
                m_is_crc <= 1'b0;
                crc      <= crc_next;
                in_frame <= 1'b1;
                if (s_last) begin
                    state <= ST_APPEND;
                end
            end else begin
                m_valid <= 1'b0;
            end
        end
        // While stalled (m_valid && !m_ready) every output register holds.
    end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_crc_frame_ctrl
//
// Scoreboard bench for crc_frame_ctrl. Each accepted input byte pushes its
// expected output beat into a queue; when a frame's last byte is accepted the
// expected CRC beat, computed by polynomial long division of the augmented
// message, is pushed too. A separate monitor pops and compares on every
// output transfer and checks that stalled beats hold stable.
// Directed scenarios come first, then randomized frames with random
// downstream backpressure. The DUT is built with a small frame counter so
// wrap-around is reached quickly.
// -----------------------------------------------------------------------------
module tb_crc_frame_ctrl;

    localparam int         CNT_W = 3;
    localparam logic [7:0] POLY  = 8'hED;
`ifdef CRC_XOROUT_EN
    localparam logic [7:0] OUT_XOR = 8'hFF;
`else
    localparam logic [7:0] OUT_XOR = 8'h00;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [7:0]       m_data;
    logic             m_last;
    logic             m_is_crc;
    logic             in_frame;
    logic [CNT_W-1:0] frame_cnt;

    crc_frame_ctrl #(
        .POLY   (8'hED),
        .INIT   (8'h00),
        .XOROUT (8'hFF),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_is_crc  (m_is_crc),
        .in_frame  (in_frame),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       is_crc;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  cur_frame[$];
    int unsigned exp_frames;
    int          compared   = 0;
    int          mismatched = 0;
    bit          rand_ready_en = 1'b0;
    bit          fixed_ready   = 1'b1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC as the remainder of M(x)*x^8 divided by the generator (INIT = 0).
    function automatic logic [7:0] crc_ref(input logic [7:0] msg[$]);
        int unsigned rem = 0;
        bit          bits[$];
        foreach (msg[k]) begin
            for (int b = 7; b >= 0; b--) bits.push_back(msg[k][b]);
        end
        for (int b = 0; b < 8; b++) bits.push_back(1'b0);
        foreach (bits[k]) begin
            rem = (rem << 1) | int'(bits[k]);
            if (rem >= 256) rem = rem ^ (256 + int'(POLY));
        end
        return rem[7:0];
    endfunction

    // Downstream ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_ready_en ? ($urandom_range(0, 3) != 0) : fixed_ready;
        end
    end

    // Stimulus side of the scoreboard: record what each accept must produce.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n && s_valid && s_ready) begin
                b = '{data: s_data, last: 1'b0, is_crc: 1'b0};
                exp_q.push_back(b);
                cur_frame.push_back(s_data);
                if (s_last) begin
                    b = '{data: crc_ref(cur_frame) ^ OUT_XOR, last: 1'b1, is_crc: 1'b1};
                    exp_q.push_back(b);
                    cur_frame.delete();
                end
            end
        end
    end

    // Output monitor: compare transfers and check stall stability.
    initial begin
        bit    prev_stall = 1'b0;
        beat_t held;
        beat_t got;
        beat_t want;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                got = '{data: m_data, last: m_last, is_crc: m_is_crc};
                if (prev_stall) begin
                    check("hold_valid", 32'(m_valid), 32'd1);
                    check("hold_beat", 32'(got), 32'(held));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", got);
                    end else begin
                        want = exp_q.pop_front();
                        check("beat", 32'(got), 32'(want));
                        if (want.is_crc) begin
                            exp_frames++;
                            check("frame_cnt_at_crc", 32'(frame_cnt),
                                  exp_frames % (1 << CNT_W));
                        end
                    end
                end
                prev_stall = m_valid && !m_ready;
                held       = got;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            compared++;
            mismatched++;
            $display("FAIL s_ready_timeout: got s_ready=0, expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || m_valid) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned len;
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        s_last     = 1'b0;
        exp_frames = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_is_crc", 32'(m_is_crc), 32'd0);
        check("rst_in_frame", 32'(in_frame), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-byte frame 0x01.
        send_byte(8'h01, 1'b1);
        check("t1_in_frame_set", 32'(in_frame), 32'd1);
        check("t1_first_out", 32'(m_data), 32'h01);
        wait_idle();
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t1_in_frame_clr", 32'(in_frame), 32'd0);

        // Frame {0x00, 0x01}: one input bubble after the last byte.
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b1);
        @(negedge clk);
        check("t2_bubble", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("t2_ready_again", 32'(s_ready), 32'd1);
        wait_idle();
        check("t2_frame_cnt", 32'(frame_cnt), 32'd2);

        // Back-to-back {0x80} then {0x01}.
        send_byte(8'h80, 1'b1);
        send_byte(8'h01, 1'b1);
        wait_idle();
        check("t3_frame_cnt", 32'(frame_cnt), 32'd4);

        // Backpressure on the payload beat.
        fixed_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'h01, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_stall_data", 32'(m_data), 32'h01);
            check("t4_stall_s_ready", 32'(s_ready), 32'd0);
        end
        fixed_ready = 1'b1;
        wait_idle();
        check("t4_frame_cnt", 32'(frame_cnt), 32'd5);

        // Reset mid-frame discards the partial frame.
        send_byte(8'h80, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_m_valid", 32'(m_valid), 32'd0);
        check("t5_in_frame", 32'(in_frame), 32'd0);
        check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
        exp_q.delete();
        cur_frame.delete();
        exp_frames = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h01, 1'b1);
        wait_idle();
        check("t5_frame_cnt_after", 32'(frame_cnt), 32'd1);

        // Counter wrap-around.
        for (int k = 1; k <= 8; k++) begin
            send_byte(8'($urandom), 1'b1);
            wait_idle();
            check("t6_wrap_cnt", 32'(frame_cnt), 32'((1 + k) % (1 << CNT_W)));
        end

        // Randomized frames with random gaps and backpressure.
        rand_ready_en = 1'b1;
        for (int f = 0; f < 60; f++) begin
            len = $urandom_range(1, 6);
            for (int unsigned k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                    s_last  = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
                send_byte(8'($urandom), k == len - 1);
            end
        end
        rand_ready_en = 1'b0;
        fixed_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wait_idle();
        check("final_in_frame", 32'(in_frame), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
